// File: rtl/freq_sweep.sv
// freq_sweep: stepped frequency sweeper for a downstream tone generator.
// A start request captures the sweep parameters, then the block walks
// freq from f_start towards f_stop in f_step increments, holding each
// value for a programmable dwell. A pass either ends (done pulse) or
// restarts from f_start (wrap pulse) depending on the captured cont bit.
// All outputs are registered; the block has a single clock and a
// synchronous active-low reset.

module freq_sweep #(
    parameter int FREQ_W  = 12,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               cont,
    input  logic [FREQ_W-1:0]  f_start,
    input  logic [FREQ_W-1:0]  f_stop,
    input  logic [FREQ_W-1:0]  f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [FREQ_W-1:0]  freq,
    output logic               en,
    output logic               busy,
    output logic               wrap,
    output logic               done
);

    localparam logic [FREQ_W-1:0]  ZERO_F = {FREQ_W{1'b0}};
    localparam logic [FREQ_W-1:0]  ONE_F  = {{(FREQ_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] ZERO_D = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] ONE_D  = {{(DWELL_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_r;
    logic [FREQ_W-1:0]   f_start_r;
    logic [FREQ_W-1:0]   f_stop_r;
    logic [FREQ_W-1:0]   f_step_r;   // already forced to >= 1
    logic [DWELL_W-1:0]  dwell_r;    // already forced to >= 1
    logic                cont_r;
    logic                dir_up_r;
    logic [DWELL_W-1:0]  cnt_r;      // cycles left at the current value, minus one

    logic [FREQ_W-1:0]   step_eff_s;
    logic [DWELL_W-1:0]  dwell_eff_s;
    logic                dir_up_s;
    logic [FREQ_W-1:0]   next_freq_s;
    logic                at_stop_s;
    logic                dwell_end_s;

    // Next sweep value: one step towards f_stop, computed one bit wider so
    // that carry/borrow out of the word is visible; anything that passes
    // f_stop or leaves the word range lands exactly on f_stop.
    function automatic logic [FREQ_W-1:0] step_toward(
        input logic [FREQ_W-1:0] cur,
        input logic [FREQ_W-1:0] step,
        input logic [FREQ_W-1:0] stop,
        input logic              up
    );
        logic [FREQ_W:0]   wide;
        logic [FREQ_W-1:0] result;
        if (up) begin
            wide = {1'b0, cur} + {1'b0, step};
            if (wide[FREQ_W] || (wide[FREQ_W-1:0] > stop)) begin
                result = stop;
            end else begin
                result = wide[FREQ_W-1:0];
            end
        end else begin
            wide = {1'b0, cur} - {1'b0, step};
            if (wide[FREQ_W] || (wide[FREQ_W-1:0] < stop)) begin
                result = stop;
            end else begin
                result = wide[FREQ_W-1:0];
            end
        end
        return result;
    endfunction

    // Sanitise the live inputs at capture time and evaluate the step logic
    // from the captured parameters.
    always_comb begin
        step_eff_s  = f_step;
        dwell_eff_s = dwell;
        dir_up_s    = 1'b0;
        if (f_step == ZERO_F) begin
            step_eff_s = ONE_F;
        end else begin
            step_eff_s = f_step;
        end
        if (dwell == ZERO_D) begin
            dwell_eff_s = ONE_D;
        end else begin
            dwell_eff_s = dwell;
        end
        if (f_stop >= f_start) begin
            dir_up_s = 1'b1;
        end else begin
            dir_up_s = 1'b0;
        end
        next_freq_s = step_toward(freq, f_step_r, f_stop_r, dir_up_r);
        at_stop_s   = (freq == f_stop_r);
        dwell_end_s = (cnt_r == ZERO_D);
    end

    // Sweep FSM with registered outputs; wrap/done are single-cycle pulses
    // and abort has priority over every end-of-dwell action.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            f_start_r <= ZERO_F;
            f_stop_r  <= ZERO_F;
            f_step_r  <= ZERO_F;
            dwell_r   <= ZERO_D;
            cont_r    <= 1'b0;
            dir_up_r  <= 1'b0;
            cnt_r     <= ZERO_D;
            freq      <= ZERO_F;
            en        <= 1'b0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && !abort) begin
                        f_start_r <= f_start;
                        f_stop_r  <= f_stop;
                        f_step_r  <= step_eff_s;
                        dwell_r   <= dwell_eff_s;
                        cont_r    <= cont;
                        dir_up_r  <= dir_up_s;
                        cnt_r     <= dwell_eff_s - ONE_D;
                        freq      <= f_start;
                        en        <= 1'b1;
                        busy      <= 1'b1;
                        state_r   <= RUN;
                    end else begin
                        freq    <= ZERO_F;
                        en      <= 1'b0;
                        busy    <= 1'b0;
                        cnt_r   <= ZERO_D;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (abort) begin
                        freq    <= ZERO_F;
                        en      <= 1'b0;
                        busy    <= 1'b0;
                        cnt_r   <= ZERO_D;
                        done    <= 1'b1;
                        state_r <= IDLE;
                    end else if (!dwell_end_s) begin
                        cnt_r <= cnt_r - ONE_D;
                    end else if (at_stop_s) begin
                        if (cont_r) begin
                            freq  <= f_start_r;
                            cnt_r <= dwell_r - ONE_D;
                            wrap  <= 1'b1;
                        end else begin
                            freq    <= ZERO_F;
                            en      <= 1'b0;
                            busy    <= 1'b0;
                            cnt_r   <= ZERO_D;
                            done    <= 1'b1;
                            state_r <= IDLE;
                        end
                    end else begin
                        freq  <= next_freq_s;
                        cnt_r <= dwell_r - ONE_D;
                    end
                end
                default: begin
                    freq    <= ZERO_F;
                    en      <= 1'b0;
                    busy    <= 1'b0;
                    cnt_r   <= ZERO_D;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_sweep.sv
// Directed testbench for freq_sweep: hand-computed sweep sequences,
// clamping, collisions, abort and reset behaviour.

module tb_freq_sweep;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        cont;
    logic [11:0] f_start;
    logic [11:0] f_stop;
    logic [11:0] f_step;
    logic [15:0] dwell;
    logic [11:0] freq;
    logic        en;
    logic        busy;
    logic        wrap;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    freq_sweep #(.FREQ_W(12), .DWELL_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .cont    (cont),
        .f_start (f_start),
        .f_stop  (f_stop),
        .f_step  (f_step),
        .dwell   (dwell),
        .freq    (freq),
        .en      (en),
        .busy    (busy),
        .wrap    (wrap),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: the sequence is linear, but never let the run hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hold a value for d cycles with the generator enabled and no pulses.
    task automatic hold(input string tag, input logic [11:0] v, input int d);
        for (int i = 0; i < d; i++) begin
            chk({tag, "_freq"}, 32'(freq), 32'(v));
            chk({tag, "_en"},   32'(en),   32'd1);
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_wrap"}, 32'(wrap), 32'd0);
            chk({tag, "_done"}, 32'(done), 32'd0);
            tick();
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, "_freq"}, 32'(freq), 32'd0);
        chk({tag, "_en"},   32'(en),   32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_wrap"}, 32'(wrap), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
    endtask

    task automatic setup(input logic [11:0] s, input logic [11:0] e, input logic [11:0] st,
                         input logic [15:0] d, input logic c);
        f_start = s;
        f_stop  = e;
        f_step  = st;
        dwell   = d;
        cont    = c;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        setup(12'd0, 12'd0, 12'd0, 16'd0, 1'b0);

        // Reset state, with start asserted during reset.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_idle("reset", 1'b0);
        rst_n = 1'b1;
        tick();
        chk_idle("post_reset", 1'b0);

        // Up sweep; inputs scrambled after capture must not matter.
        setup(12'd100, 12'd130, 12'd10, 16'd3, 1'b0);
        pulse_start();
        setup(12'd7, 12'd4000, 12'd1, 16'd9, 1'b1);
        hold("up100", 12'd100, 3);
        hold("up110", 12'd110, 3);
        hold("up120", 12'd120, 3);
        hold("up130", 12'd130, 3);
        chk_idle("up_end", 1'b1);
        tick();
        chk_idle("up_after", 1'b0);

        // Down sweep with clamp on f_stop.
        setup(12'd50, 12'd20, 12'd25, 16'd2, 1'b0);
        pulse_start();
        hold("dn50", 12'd50, 2);
        hold("dn25", 12'd25, 2);
        hold("dn20", 12'd20, 2);
        chk_idle("dn_end", 1'b1);
        tick();

        // Continuous: 0,2,4,0(wrap),2,4 then abort at the end-of-pass cycle.
        setup(12'd0, 12'd4, 12'd2, 16'd1, 1'b1);
        pulse_start();
        hold("c0", 12'd0, 1);
        hold("c2", 12'd2, 1);
        hold("c4", 12'd4, 1);
        chk("cwrap_freq", 32'(freq), 32'd0);
        chk("cwrap_wrap", 32'(wrap), 32'd1);
        chk("cwrap_done", 32'(done), 32'd0);
        chk("cwrap_busy", 32'(busy), 32'd1);
        tick();
        hold("c2b", 12'd2, 1);
        chk("c4b_freq", 32'(freq), 32'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("cabort", 1'b1);
        tick();
        chk_idle("cabort_after", 1'b0);

        // Zero step and zero dwell behave as 1.
        setup(12'd10, 12'd13, 12'd0, 16'd0, 1'b0);
        pulse_start();
        hold("z10", 12'd10, 1);
        hold("z11", 12'd11, 1);
        hold("z12", 12'd12, 1);
        hold("z13", 12'd13, 1);
        chk_idle("z_end", 1'b1);
        tick();

        // Single value at the top of range.
        setup(12'd4095, 12'd4095, 12'd5, 16'd2, 1'b0);
        pulse_start();
        hold("top", 12'd4095, 2);
        chk_idle("top_end", 1'b1);
        tick();

        // Overflow clamps to f_stop.
        setup(12'd4000, 12'd4095, 12'd200, 16'd1, 1'b0);
        pulse_start();
        hold("ov4000", 12'd4000, 1);
        hold("ov4095", 12'd4095, 1);
        chk_idle("ov_end", 1'b1);
        tick();

        // Underflow clamps to f_stop.
        setup(12'd30, 12'd5, 12'd40, 16'd1, 1'b0);
        pulse_start();
        hold("un30", 12'd30, 1);
        hold("un5", 12'd5, 1);
        chk_idle("un_end", 1'b1);
        tick();

        // Abort and start collisions in IDLE.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("idle_abort", 1'b0);
        setup(12'd100, 12'd130, 12'd10, 16'd3, 1'b0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk_idle("both_idle", 1'b0);
        tick();
        chk_idle("both_idle2", 1'b0);

        // Abort during the second step, restart two cycles later.
        pulse_start();
        hold("ab100", 12'd100, 3);
        hold("ab110", 12'd110, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("ab_done", 1'b1);
        tick();
        chk_idle("ab_gap1", 1'b0);
        tick();
        chk_idle("ab_gap2", 1'b0);

        // Restart, with a start request mid-sweep that must be ignored.
        pulse_start();
        hold("rs100a", 12'd100, 1);
        setup(12'd900, 12'd950, 12'd1, 16'd1, 1'b1);
        start = 1'b1;
        hold("rs100b", 12'd100, 1);
        start = 1'b0;
        hold("rs100c", 12'd100, 1);
        hold("rs110", 12'd110, 2);

        // Reset mid-RUN: everything clears and no done follows.
        rst_n = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("rst_run", 1'b0);
        rst_n = 1'b1;
        tick();
        chk_idle("rst_after1", 1'b0);
        tick();
        chk_idle("rst_after2", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_sweep.md
FREQ_SWEEP -- requirements
Module: freq_sweep

Interface
REQ-001 Parameter FREQ_W, 12, width of frequency-step words; matches the phase-increment input of the downstream tone generators.
REQ-002 Parameter DWELL_W, 16, width of the dwell counter.
REQ-003 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a sweep.
REQ-006 abort  in  1  one-cycle request to end a sweep immediately.
REQ-007 cont  in  1  1 = repeat passes indefinitely; 0 = single pass.
REQ-008 f_start  in  FREQ_W  first frequency word of a pass.
REQ-009 f_stop  in  FREQ_W  last frequency word of a pass.
REQ-010 f_step  in  FREQ_W  increment magnitude per step; 0 SHALL be treated as 1.
REQ-011 dwell  in  DWELL_W  cycles each frequency is held; 0 SHALL be treated as 1.
REQ-012 freq  out  FREQ_W  frequency word to the generator; registered.
REQ-013 en  out  1  generator enable; registered.
REQ-014 busy  out  1  high while a sweep is active.
REQ-015 wrap  out  1  one-cycle pulse when a continuous pass restarts.
REQ-016 done  out  1  one-cycle pulse when a single pass completes or an abort takes effect.

Function
REQ-017 The FSM SHALL have two states: IDLE and RUN.
REQ-018 In IDLE, a sampled start with abort low SHALL latch f_start, f_stop, f_step, dwell, and cont into internal registers; direction SHALL be up if f_stop >= f_start, else down.
REQ-019 The cycle after the start is sampled: freq = f_start, en = 1, busy = 1, state = RUN, dwell counter loaded.
REQ-020 Input changes during RUN SHALL NOT affect the active sweep.
REQ-021 Each freq value SHALL be held for exactly D cycles, where D = max(dwell, 1).
REQ-022 Step rule: the next value SHALL be freq ± step, computed at FREQ_W+1 bits; if the result passes f_stop or overflows or underflows, freq SHALL clamp to f_stop.
REQ-023 End of dwell with freq == f_stop and cont = 1: freq reloads to f_start, wrap pulses for one cycle, and RUN continues.
REQ-024 End of dwell with freq == f_stop and cont = 0: the FSM returns to IDLE; freq = 0, en = 0, busy = 0, and done pulses for one cycle.
REQ-025 f_start == f_stop SHALL give a one-value pass: hold D cycles, then wrap or done.
REQ-026 Abort sampled in RUN SHALL take effect next cycle: state IDLE, freq = 0, en = 0, busy = 0, done = 1 for one cycle, wrap = 0.
REQ-027 Abort sampled in IDLE SHALL be ignored; done stays 0.
REQ-028 Start and abort sampled together in IDLE: abort wins; the FSM stays in IDLE with no pulses.
REQ-029 Start sampled in RUN SHALL be ignored.
REQ-030 Abort coinciding with an end-of-pass event: abort wins; wrap = 0 and done pulses once.
REQ-031 wrap and done SHALL never be high in the same cycle.

Reset
REQ-032 rst_n low at a clock edge SHALL force state = IDLE and freq = 0, en = 0, busy = 0, wrap = 0, done = 0, counter = 0, all latched parameters = 0, regardless of state.
REQ-033 Reset SHALL override start and abort in the same cycle; no done pulse SHALL follow a reset.

Verification
REQ-034 Up sweep: f_start = 100, f_stop = 130, f_step = 10, dwell = 3, cont = 0 -> freq = 100, 110, 120, 130, each for 3 cycles; then done pulses once, en = 0, freq = 0.
REQ-035 Clamp and down sweep: f_start = 50, f_stop = 20, f_step = 25, dwell = 2 -> freq = 50, 25, 20, each for 2 cycles; then done.
REQ-036 Continuous: f_start = 0, f_stop = 4, f_step = 2, dwell = 1, cont = 1 -> freq = 0, 2, 4, 0, 2, ...; wrap is high in the cycle freq returns to 0; no done.
REQ-037 Edges: f_step = 0 and dwell = 0 -> freq steps by 1 every cycle; f_start = 4095, f_stop = 4095 -> one 4095 value, then done.
REQ-038 Abort and reset mid-sweep: abort during the second step -> next cycle freq = 0, en = 0, done = 1; start again after 2 cycles restarts from f_start; rst_n low mid-RUN -> all outputs 0 and no done pulse.
REQ-039 Collisions: start and abort together in IDLE -> no activity; start during RUN -> the sweep sequence is unchanged.
